output_buffer: RTL and testbench

OUTPUT_BUFFER -- requirements
Module: output_buffer

---
 rtl/output_buffer.sv | 159 +++++++++++++++
 tb/tb_output_buffer.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/output_buffer.sv
// Decoupling FIFO between the filter output and the downstream sink.
// Both sides use four-phase req/ack handshakes, and each sample carries a rolling stream tag.
module output_buffer #(
    parameter int DWIDTH         = 16,
    parameter int DEPTH_LOG      = 4,
    parameter int NR_STREAMS     = 16,
    parameter int NR_STREAMS_LOG = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        req_in,
    output logic                        ack_in,
    input  logic [0:DWIDTH-1]           data_in,
    output logic                        req_out,
    input  logic                        ack_out,
    output logic [0:DWIDTH-1]           data_out,
    output logic [0:NR_STREAMS_LOG-1]   stream_out,
    output logic [0:DEPTH_LOG]          count
);

    localparam int DEPTH = 1 << DEPTH_LOG;
    localparam logic [DEPTH_LOG:0]        COUNT_FULL = (DEPTH_LOG+1)'(DEPTH);
    localparam logic [NR_STREAMS_LOG-1:0] TAG_LAST   = NR_STREAMS_LOG'(NR_STREAMS-1);

    typedef enum logic {
        IN_IDLE,
        IN_ACK
    } in_state_t;

    typedef enum logic [1:0] {
        OUT_IDLE,
        OUT_REQ,
        OUT_WAIT
    } out_state_t;

    in_state_t                  in_state_q, in_state_d;
    out_state_t                 out_state_q, out_state_d;
    logic [DEPTH_LOG-1:0]       wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG-1:0]       rd_ptr_q, rd_ptr_d;
    logic [NR_STREAMS_LOG-1:0]  tag_q, tag_d;
    logic [DEPTH_LOG:0]         count_q, count_d;
    logic                       ack_in_q, ack_in_d;
    logic                       req_out_q, req_out_d;
    logic [DWIDTH-1:0]          data_out_q, data_out_d;
    logic [NR_STREAMS_LOG-1:0]  stream_out_q, stream_out_d;
    logic                       push, pop;

    logic [DWIDTH-1:0]          mem_data_q [DEPTH];
    logic [NR_STREAMS_LOG-1:0]  mem_tag_q  [DEPTH];

    // Full is judged on the registered count, so a pop on the same edge cannot free a slot early.
    always_comb begin
        in_state_d = in_state_q;
        ack_in_d   = ack_in_q;
        push       = 1'b0;
        case (in_state_q)
            IN_IDLE: begin
                if (req_in && (count_q != COUNT_FULL)) begin
                    push       = 1'b1;
                    ack_in_d   = 1'b1;
                    in_state_d = IN_ACK;
                end
            end
            IN_ACK: begin
                if (!req_in) begin
                    ack_in_d   = 1'b0;
                    in_state_d = IN_IDLE;
                end
            end
            default: begin
                ack_in_d   = 1'b0;
                in_state_d = IN_IDLE;
            end
        endcase
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        if (push) tag_d = (tag_q == TAG_LAST) ? '0 : tag_q + 1'b1;
        else      tag_d = tag_q;
    end

    // The head entry stays counted while it is being offered; it is popped only on ack_out.
    always_comb begin
        out_state_d  = out_state_q;
        req_out_d    = req_out_q;
        data_out_d   = data_out_q;
        stream_out_d = stream_out_q;
        pop          = 1'b0;
        case (out_state_q)
            OUT_IDLE: begin
                if (count_q != '0) begin
                    data_out_d   = mem_data_q[rd_ptr_q];
                    stream_out_d = mem_tag_q[rd_ptr_q];
                    req_out_d    = 1'b1;
                    out_state_d  = OUT_REQ;
                end
            end
            OUT_REQ: begin
                if (ack_out) begin
                    req_out_d   = 1'b0;
                    pop         = 1'b1;
                    out_state_d = OUT_WAIT;
                end
            end
            OUT_WAIT: begin
                if (!ack_out) out_state_d = OUT_IDLE;
            end
            default: begin
                req_out_d   = 1'b0;
                out_state_d = OUT_IDLE;
            end
        endcase
        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_state_q   <= IN_IDLE;
            out_state_q  <= OUT_IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            tag_q        <= '0;
            count_q      <= '0;
            ack_in_q     <= 1'b0;
            req_out_q    <= 1'b0;
            data_out_q   <= '0;
            stream_out_q <= '0;
        end else begin
            in_state_q   <= in_state_d;
            out_state_q  <= out_state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            tag_q        <= tag_d;
            count_q      <= count_d;
            ack_in_q     <= ack_in_d;
            req_out_q    <= req_out_d;
            data_out_q   <= data_out_d;
            stream_out_q <= stream_out_d;
        end
    end

    // Storage needs no reset: the pointers and count alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_data_q[wr_ptr_q] <= data_in;
            mem_tag_q[wr_ptr_q]  <= tag_q;
        end
    end

    assign ack_in     = ack_in_q;
    assign req_out    = req_out_q;
    assign data_out   = data_out_q;
    assign stream_out = stream_out_q;
    assign count      = count_q;

endmodule

// File: tb/tb_output_buffer.sv
// Randomized and directed bench for output_buffer.
// A queue-based reference model predicts handshakes, occupancy and delivered samples.
module tb_output_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_in;
    logic        ack_in;
    logic [0:15] data_in;
    logic        req_out;
    logic        ack_out;
    logic [0:15] data_out;
    logic [0:3]  stream_out;
    logic [0:4]  count;

    output_buffer #(
        .DWIDTH(16), .DEPTH_LOG(4), .NR_STREAMS(16), .NR_STREAMS_LOG(4)
    ) dut (
        .clk(clk), .rst(rst),
        .req_in(req_in), .ack_in(ack_in), .data_in(data_in),
        .req_out(req_out), .ack_out(ack_out),
        .data_out(data_out), .stream_out(stream_out), .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] d;
        int          t;
    } item_t;

    item_t       m_q[$];
    int          m_tag;
    bit          m_ack_in;
    int          m_ph;        // 0 idle, 1 offering, 2 waiting for ack release
    logic [15:0] m_data;
    int          m_stag;
    bit          auto_sink;
    int          log_t[$];
    logic [15:0] log_d[$];

    int vectors     = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_tag    = 0;
        m_ack_in = 0;
        m_ph     = 0;
        m_data   = '0;
        m_stag   = 0;
    endtask

    // One clock: predict the edge from the inputs held across it, then compare.
    task automatic tick();
        int    sz;
        bit    do_push, do_pop, prev_req;
        item_t it;
        if (auto_sink) ack_out = req_out;
        sz      = m_q.size();
        do_push = req_in && !m_ack_in && (sz < 16);
        do_pop  = (m_ph == 1) && ack_out;
        if (!m_ack_in) m_ack_in = do_push;
        else if (!req_in) m_ack_in = 0;
        case (m_ph)
            0: if (sz > 0) begin
                m_data = m_q[0].d;
                m_stag = m_q[0].t;
                m_ph   = 1;
            end
            1: if (ack_out) m_ph = 2;
            2: if (!ack_out) m_ph = 0;
            default: m_ph = 0;
        endcase
        if (do_pop) void'(m_q.pop_front());
        if (do_push) begin
            it.d = data_in;
            it.t = m_tag;
            m_q.push_back(it);
            m_tag = (m_tag + 1) % 16;
        end
        prev_req = req_out;
        @(posedge clk);
        #1;
        chk("ack_in", ack_in, m_ack_in);
        chk("req_out", req_out, (m_ph == 1));
        chk("count", count, m_q.size());
        chk("data_out", data_out, m_data);
        chk("stream_out", stream_out, m_stag);
        if (req_out && !prev_req) begin
            log_t.push_back(int'(stream_out));
            log_d.push_back(data_out);
        end
    endtask

    task automatic wait_ack_in(input bit v, input int lim, input string tag);
        int n = 0;
        while (ack_in !== v && n < lim) begin
            tick();
            n++;
        end
        if (ack_in !== v) chk(tag, ack_in, v);
    endtask

    task automatic push_sample(input logic [15:0] d);
        req_in  = 1'b1;
        data_in = d;
        wait_ack_in(1'b1, 60, "push_ack_timeout");
        req_in = 1'b0;
        wait_ack_in(1'b0, 60, "push_release_timeout");
    endtask

    task automatic drain();
        int n = 0;
        auto_sink = 1'b1;
        while ((m_q.size() > 0 || m_ph != 0) && n < 400) begin
            tick();
            n++;
        end
        chk("drain_count", count, 0);
        auto_sink = 1'b0;
        ack_out   = 1'b0;
    endtask

    task automatic run_random(input int cycles, input int in_rate, input int sink_rate);
        for (int n = 0; n < cycles; n++) begin
            if (!req_in && !ack_in && $urandom_range(0, in_rate) == 0) begin
                req_in  = 1'b1;
                data_in = 16'($urandom);
            end else if (req_in && ack_in && $urandom_range(0, 1) == 0) begin
                req_in = 1'b0;
            end
            if (req_out && !ack_out && $urandom_range(0, sink_rate) == 0)
                ack_out = 1'b1;
            else if (!req_out && ack_out && $urandom_range(0, 1) == 0)
                ack_out = 1'b0;
            else if (!req_out && !ack_out && $urandom_range(0, 40) == 0)
                ack_out = 1'b1;
            tick();
        end
        req_in = 1'b0;
        wait_ack_in(1'b0, 60, "rand_release_timeout");
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b0;
        req_in    = 1'b0;
        data_in   = '0;
        ack_out   = 1'b0;
        auto_sink = 1'b0;
        model_reset();
        #3;
        chk("rst_ack_in", ack_in, 0);
        chk("rst_req_out", req_out, 0);
        chk("rst_count", count, 0);
        chk("rst_data_out", data_out, 0);
        chk("rst_stream_out", stream_out, 0);
        @(posedge clk);
        #1 rst = 1'b1;

        // Single sample through an empty buffer.
        req_in  = 1'b1;
        data_in = 16'h1234;
        tick();
        chk("single_ack", ack_in, 1);
        chk("single_no_req_yet", req_out, 0);
        req_in = 1'b0;
        tick();
        chk("single_req", req_out, 1);
        chk("single_data", data_out, 16'h1234);
        chk("single_tag", stream_out, 0);
        ack_out = 1'b1;
        tick();
        ack_out = 1'b0;
        tick();
        chk("single_count", count, 0);

        // Fill against a stalled sink; the 17th request must wait for a pop.
        for (int i = 0; i < 16; i++) push_sample(16'($urandom));
        chk("fill_count", count, 16);
        req_in  = 1'b1;
        data_in = 16'hF17F;
        repeat (5) tick();
        chk("fill_stall", ack_in, 0);
        ack_out = 1'b1;
        tick();
        chk("fill_pop_no_write", ack_in, 0);
        ack_out = 1'b0;
        tick();
        chk("fill_17_ack", ack_in, 1);
        chk("fill_17_count", count, 16);
        req_in = 1'b0;
        wait_ack_in(1'b0, 60, "fill_release_timeout");
        drain();

        // Push and pop on the same edge at occupancy 5.
        for (int i = 0; i < 5; i++) push_sample(16'h5000 + 16'(i));
        chk("simul_pre_count", count, 5);
        chk("simul_pre_req", req_out, 1);
        req_in  = 1'b1;
        data_in = 16'h5555;
        ack_out = 1'b1;
        tick();
        chk("simul_count", count, 5);
        ack_out = 1'b0;
        req_in  = 1'b0;
        wait_ack_in(1'b0, 60, "simul_release_timeout");
        drain();

        // ack_out asserted while idle must not pop anything.
        ack_out = 1'b1;
        repeat (4) tick();
        chk("spur_count", count, 0);
        ack_out = 1'b0;
        tick();

        run_random(1500, 3, 7);
        run_random(1500, 1, 1);

        // Reset while offering with 7 entries; afterwards tags restart at 0.
        for (int i = 0; i < 7; i++) push_sample(16'h7000 + 16'(i));
        chk("rstmid_pre_count", count, 7);
        chk("rstmid_pre_req", req_out, 1);
        #2 rst = 1'b0;
        #1;
        chk("rstmid_req_out", req_out, 0);
        chk("rstmid_count", count, 0);
        chk("rstmid_stream_out", stream_out, 0);
        chk("rstmid_data_out", data_out, 0);
        chk("rstmid_ack_in", ack_in, 0);
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;

        // Twenty samples streamed through: tags 0..15 then 0..3, data order intact.
        log_t.delete();
        log_d.delete();
        auto_sink = 1'b1;
        for (int i = 0; i < 20; i++) push_sample(16'(i));
        drain();
        chk("wrap_len", log_t.size(), 20);
        for (int i = 0; i < log_t.size() && i < 20; i++) begin
            chk("wrap_tag", log_t[i], i % 16);
            chk("wrap_data", log_d[i], i);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
